// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
// Imported by the bus mux and its default slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ERR1 = 2'd1,
    D_ERR2 = 2'd2
  } dstate_e;

  function automatic logic is_xfer(logic [1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped active
// transfers, plus a saturating count of error responses.
module ahblite_default_slave
  import ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic        hit,
  output logic        ready,
  output logic        resp,
  output logic        active,
  output logic [15:0] ERR_CNT
);

  dstate_e     state;
  dstate_e     state_nxt;
  logic [15:0] cnt;
  logic        err_req;

  assign err_req = HREADY & is_xfer(HTRANS) & ~hit;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= D_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      D_IDLE: if (err_req) state_nxt = D_ERR1;
      D_ERR1: state_nxt = D_ERR2;
      D_ERR2: state_nxt = err_req ? D_ERR1 : D_IDLE;
      default: state_nxt = D_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt <= '0;
    end else if (state_nxt == D_ERR1 &&
                 state != D_ERR1 &&
                 cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign ready   = (state != D_ERR1);
  assign resp    = (state != D_IDLE) ? HRESP_ERROR : HRESP_OKAY;
  assign active  = (state != D_IDLE);
  assign ERR_CNT = cnt;

endmodule

// File: rtl/ahblite_bus_mux.sv
// AHB-Lite page decoder and data-phase response mux with a
// built-in default slave for unmapped pages.
module ahblite_bus_mux
  import ahb_pkg::*;
#(
  parameter int                     NS        = 6,
  parameter int                     PAGE_W    = 8,
  parameter logic [NS*PAGE_W-1:0]   SLV_PAGES =
    {8'h40, 8'h4A, 8'h49, 8'h48, 8'h20, 8'h00},
  parameter logic [31:0]            DEF_RDATA = 32'hDEADBEEF
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  output logic [31:0]      HRDATA,
  output logic             HREADY,
  output logic             HRESP,
  output logic [NS-1:0]    HSEL,
  input  logic [NS-1:0]    HREADY_S,
  input  logic [NS*32-1:0] HRDATA_S,
  input  logic [NS-1:0]    HRESP_S,
  output logic [15:0]      ERR_CNT
);

  if (NS < 1 || NS > 16 || PAGE_W < 1 || PAGE_W > 32) begin : g_bad
    $error("ahblite_bus_mux: NS or PAGE_W out of range");
  end

  logic [PAGE_W-1:0] page;
  logic [NS-1:0]     owner;
  logic              hit;
  logic              found;
  logic              d_ready;
  logic              d_resp;
  logic              d_active;
  logic [31:0]       s_rdata;
  logic              s_ready;
  logic              s_resp;

  assign page = HADDR[31 -: PAGE_W];

  // Lowest index wins when two slaves share a page.
  always_comb begin
    HSEL  = '0;
    found = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!found && page == SLV_PAGES[i*PAGE_W +: PAGE_W]) begin
        HSEL[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign hit = |HSEL;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner <= '0;
    end else if (HREADY) begin
      owner <= HSEL;
    end
  end

  always_comb begin
    s_rdata = DEF_RDATA;
    s_ready = 1'b1;
    s_resp  = HRESP_OKAY;
    for (int i = 0; i < NS; i++) begin
      if (owner[i]) begin
        s_rdata = HRDATA_S[i*32 +: 32];
        s_ready = HREADY_S[i];
        s_resp  = HRESP_S[i];
      end
    end
  end

  // An error response in flight overrides any slave mux path.
  always_comb begin
    HRDATA = s_rdata;
    HREADY = s_ready;
    HRESP  = s_resp;
    if (d_active) begin
      HRDATA = DEF_RDATA;
      HREADY = d_ready;
      HRESP  = d_resp;
    end
  end

  ahblite_default_slave u_dflt (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .HREADY  (HREADY),
    .HTRANS  (HTRANS),
    .hit     (hit),
    .ready   (d_ready),
    .resp    (d_resp),
    .active  (d_active),
    .ERR_CNT (ERR_CNT)
  );

endmodule

// File: tb/tb_ahblite_bus_mux.sv
// Directed bench for ahblite_bus_mux with a transaction-level
// reference model compared every cycle.
module tb_ahblite_bus_mux;
  import ahb_pkg::*;

  localparam int NS = 6;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic [31:0]      HRDATA;
  logic             HREADY;
  logic             HRESP;
  logic [NS-1:0]    HSEL;
  logic [NS-1:0]    HREADY_S;
  logic [NS*32-1:0] HRDATA_S;
  logic [NS-1:0]    HRESP_S;
  logic [15:0]      ERR_CNT;

  ahblite_bus_mux dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HRDATA   (HRDATA),
    .HREADY   (HREADY),
    .HRESP    (HRESP),
    .HSEL     (HSEL),
    .HREADY_S (HREADY_S),
    .HRDATA_S (HRDATA_S),
    .HRESP_S  (HRESP_S),
    .ERR_CNT  (ERR_CNT)
  );

  always #5 HCLK = ~HCLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: slave map, data-phase owner, remaining
  // error-response cycles, error count.
  logic [7:0] pages [NS] = '{8'h00, 8'h20, 8'h48,
                             8'h49, 8'h4A, 8'h40};
  int m_owner = -1;
  int m_err   = 0;
  int m_cnt   = 0;

  function automatic int slave_of(logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (a[31:24] == pages[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_hsel();
    int s;
    s = slave_of(HADDR);
    return (s < 0) ? 32'd0 : (32'd1 << s);
  endfunction

  function automatic logic exp_ready();
    if (m_err == 2) return 1'b0;
    if (m_err == 1) return 1'b1;
    if (m_owner >= 0) return HREADY_S[m_owner];
    return 1'b1;
  endfunction

  function automatic logic exp_resp();
    if (m_err > 0) return 1'b1;
    if (m_owner >= 0) return HRESP_S[m_owner];
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (m_err == 0 && m_owner >= 0)
      return HRDATA_S[m_owner*32 +: 32];
    return 32'hDEADBEEF;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_owner = -1;
      m_err   = 0;
      m_cnt   = 0;
    end else begin
      logic smp;
      int   s;
      smp = exp_ready();
      s   = slave_of(HADDR);
      if (m_err == 2) begin
        m_err = 1;
      end else if (smp && HTRANS[1] && s < 0) begin
        m_err = 2;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_err = 0;
      end
      if (smp) m_owner = s;
    end
  end

  always @(negedge HCLK) begin
    check("hsel",   32'(HSEL),    exp_hsel());
    check("hready", 32'(HREADY),  32'(exp_ready()));
    check("hresp",  32'(HRESP),   32'(exp_resp()));
    check("hrdata", HRDATA,       exp_rdata());
    check("errcnt", 32'(ERR_CNT), 32'(m_cnt));
  end

  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  task automatic lit(string name, logic [31:0] act,
                     logic [31:0] exp);
    check({"lit_", name}, act, exp);
  endtask

  initial begin
    HRESETn  = 1'b0;
    HADDR    = 32'h4000_0000;
    HTRANS   = HTRANS_IDLE;
    HREADY_S = '1;
    HRESP_S  = '0;
    for (int i = 0; i < NS; i++)
      HRDATA_S[i*32 +: 32] = 32'h1111_0000 + 32'(i);

    // reset state
    @(negedge HCLK);
    lit("rst_ready", 32'(HREADY), 32'd1);
    lit("rst_resp",  32'(HRESP),  32'd0);
    lit("rst_rdata", HRDATA,      32'hDEADBEEF);
    lit("rst_cnt",   32'(ERR_CNT), 32'd0);
    lit("rst_hsel",  32'(HSEL),   32'h20);
    step();
    HRESETn = 1'b1;

    // mapped read with two wait states from slave 1
    step();
    HADDR  = 32'h2000_0010;
    HTRANS = HTRANS_NONSEQ;
    @(negedge HCLK);
    lit("r1_hsel", 32'(HSEL), 32'h02);
    step();
    HADDR       = 32'h0000_0000;
    HTRANS      = HTRANS_IDLE;
    HREADY_S[1] = 1'b0;
    @(negedge HCLK);
    lit("r1_wait1", 32'(HREADY), 32'd0);
    step();
    @(negedge HCLK);
    lit("r1_wait2", 32'(HREADY), 32'd0);
    step();
    HREADY_S[1] = 1'b1;
    @(negedge HCLK);
    lit("r1_done",  32'(HREADY), 32'd1);
    lit("r1_rdata", HRDATA,      32'h1111_0001);
    lit("r1_resp",  32'(HRESP),  32'd0);

    // unmapped NONSEQ -> two-cycle ERROR
    step();
    HADDR  = 32'h5000_0000;
    HTRANS = HTRANS_NONSEQ;
    @(negedge HCLK);
    lit("e1_hsel", 32'(HSEL), 32'h00);
    step();
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    lit("e1_c1_ready", 32'(HREADY),  32'd0);
    lit("e1_c1_resp",  32'(HRESP),   32'd1);
    lit("e1_c1_rdata", HRDATA,       32'hDEADBEEF);
    lit("e1_cnt",      32'(ERR_CNT), 32'd1);
    step();
    @(negedge HCLK);
    lit("e1_c2_ready", 32'(HREADY), 32'd1);
    lit("e1_c2_resp",  32'(HRESP),  32'd1);

    // IDLE then BUSY to unmapped page -> zero-wait OKAY
    step();
    HTRANS = HTRANS_BUSY;
    @(negedge HCLK);
    lit("idle_ready", 32'(HREADY), 32'd1);
    lit("idle_resp",  32'(HRESP),  32'd0);
    step();
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    lit("busy_ready", 32'(HREADY),  32'd1);
    lit("busy_resp",  32'(HRESP),   32'd0);
    lit("busy_rdata", HRDATA,       32'hDEADBEEF);
    lit("busy_cnt",   32'(ERR_CNT), 32'd1);

    // reset asserted during the wait cycle of an ERROR
    step();
    HTRANS = HTRANS_NONSEQ;
    step();
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    lit("ra_err1", 32'(HREADY),  32'd0);
    lit("ra_cnt",  32'(ERR_CNT), 32'd2);
    #1 HRESETn = 1'b0;
    #1;
    lit("ra_ready", 32'(HREADY),  32'd1);
    lit("ra_resp",  32'(HRESP),   32'd0);
    lit("ra_cnt0",  32'(ERR_CNT), 32'd0);
    step();
    step();
    HRESETn = 1'b1;

    // two unmapped NONSEQ back to back
    step();
    HADDR  = 32'h5100_0000;
    HTRANS = HTRANS_NONSEQ;
    step();
    @(negedge HCLK);
    lit("bb_e1_ready", 32'(HREADY), 32'd0);
    step();
    @(negedge HCLK);
    lit("bb_e2_ready", 32'(HREADY), 32'd1);
    lit("bb_e2_resp",  32'(HRESP),  32'd1);
    step();
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    lit("bb_e3_ready", 32'(HREADY), 32'd0);
    lit("bb_e3_resp",  32'(HRESP),  32'd1);
    step();
    @(negedge HCLK);
    lit("bb_e4_resp", 32'(HRESP), 32'd1);
    step();
    @(negedge HCLK);
    lit("bb_end_resp", 32'(HRESP),   32'd0);
    lit("bb_cnt",      32'(ERR_CNT), 32'd2);

    // pipelined slave 2 then slave 3, slave 2 stalls once
    step();
    HADDR  = 32'h4800_0000;
    HTRANS = HTRANS_NONSEQ;
    @(negedge HCLK);
    lit("p_hsel2", 32'(HSEL), 32'h04);
    step();
    HADDR       = 32'h4900_0000;
    HREADY_S[2] = 1'b0;
    @(negedge HCLK);
    lit("p_stall",  32'(HREADY), 32'd0);
    lit("p_hsel3",  32'(HSEL),   32'h08);
    step();
    HREADY_S[2] = 1'b1;
    @(negedge HCLK);
    lit("p_rd2",   HRDATA,       32'h1111_0002);
    lit("p_rdy2",  32'(HREADY),  32'd1);
    step();
    HADDR      = 32'h5000_0000;
    HTRANS     = HTRANS_IDLE;
    HRESP_S[3] = 1'b1;
    @(negedge HCLK);
    lit("p_rd3",   HRDATA,      32'h1111_0003);
    lit("p_resp3", 32'(HRESP),  32'd1);
    step();
    HRESP_S[3] = 1'b0;

    // saturation of the error counter
    step();
    force dut.u_dflt.cnt = 16'hFFFF;
    m_cnt = 65535;
    step();
    release dut.u_dflt.cnt;
    @(negedge HCLK);
    lit("sat_pre", 32'(ERR_CNT), 32'h0000_FFFF);
    step();
    HTRANS = HTRANS_NONSEQ;
    step();
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    lit("sat_err1", 32'(HREADY), 32'd0);
    step();
    step();
    @(negedge HCLK);
    lit("sat_cnt", 32'(ERR_CNT), 32'h0000_FFFF);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
